// File: rtl/hourglass_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hourglass_ctrl
// Description : Sequencer for the LED hourglass datapath. It owns the flow
//               direction, the grain count of the draining bulb and the
//               seconds-remaining countdown. It issues one-cycle step/mirror
//               commands to the LED shift logic.
//
// Parameters  : CLK_HZ    - clock cycles per one-second tick
//               C         - grains per bulb (1..8)
//               N         - seconds per grain (C*N <= 127)
//               START_DIR - flow direction after reset (0 = left bulb drains)
//
// Ports       : clk        in   system clock
//               rst        in   asynchronous reset, active-high
//               flip       in   1-cycle pulse, hourglass turned over
//               pause      in   level, freezes timing while high
//               step       out  1-cycle pulse, move one grain in direction dir
//               mirror     out  1-cycle pulse, datapath bit-reverses both bulbs
//               dir        out  current flow direction
//               grains_top out  grains left in the draining bulb (0..C)
//               sec_left   out  seconds until the draining bulb is empty
//               state      out  IDLE=0 RUN=1 HOLD=2 EMPTY=3
//               done       out  1-cycle pulse when RUN drains into EMPTY
//
// Build option: HOURGLASS_AUTOFLIP_EN - when defined, an empty hourglass
//               flips itself over one second after emptying.
//
// Revision    : 1.0 - initial release
// ============================================================================
module hourglass_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int C         = 4,
  parameter int N         = 2,
  parameter bit START_DIR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flip,
  input  logic       pause,
  output logic       step,
  output logic       mirror,
  output logic       dir,
  output logic [3:0] grains_top,
  output logic [6:0] sec_left,
  output logic [1:0] state,
  output logic       done
);

  // A one-cycle-per-second prescaler still needs at least one bit.
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [GW-1:0] GS_MAX  = GW'(N - 1);
  localparam logic [3:0]    C_G     = 4'(C);
  localparam logic [6:0]    N_S     = 7'(N);
  localparam logic [6:0]    CN_S    = 7'(C * N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    EMPTY = 2'd3
  } state_t;

  state_t          st;
  logic [PW-1:0]   prescaler;
  logic [GW-1:0]   grain_sec;

  logic            pre_end;
  logic [3:0]      g_flip;
  logic [6:0]      sec_flip;
  logic            flip_any;

  assign state    = st;
  assign pre_end  = (prescaler == PRE_MAX);
  // After a flip the former bottom bulb drains; its content is C - grains_top.
  assign g_flip   = C_G - grains_top;
  assign sec_flip = {3'b000, g_flip} * N_S;

`ifdef HOURGLASS_AUTOFLIP_EN
  // The prescaler only advances in EMPTY/RUN, and RUN never reaches here
  // through this term, so the internal flip only fires one second after
  // emptying. An external flip in that window is simply OR'ed in.
  assign flip_any = flip | ((st == EMPTY) & pre_end);
`else
  assign flip_any = flip;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      dir        <= START_DIR;
      grains_top <= C_G;
      sec_left   <= CN_S;
      prescaler  <= '0;
      grain_sec  <= '0;
      step       <= 1'b0;
      mirror     <= 1'b0;
      done       <= 1'b0;
    end else begin
      step   <= 1'b0;
      mirror <= 1'b0;
      done   <= 1'b0;

      case (st)
        IDLE: begin
          // Counters still hold their reset values, so starting needs no
          // datapath update and no mirror.
          if (flip) begin
            st <= pause ? HOLD : RUN;
          end
        end

        default: begin
          if (flip_any) begin
            // Flip takes priority over a coincident tick: that tick is lost.
            dir        <= ~dir;
            mirror     <= 1'b1;
            grains_top <= g_flip;
            sec_left   <= sec_flip;
            prescaler  <= '0;
            grain_sec  <= '0;
            if (g_flip == 4'd0) begin
              st <= EMPTY;
            end else if (st == HOLD) begin
              st <= HOLD;
            end else begin
              st <= RUN;
            end
          end else if (st == RUN) begin
            if (pause) begin
              st <= HOLD;
            end else if (pre_end) begin
              prescaler <= '0;
              sec_left  <= (sec_left == 7'd0) ? 7'd0 : sec_left - 7'd1;
              if (grain_sec == GS_MAX) begin
                grain_sec  <= '0;
                step       <= 1'b1;
                grains_top <= grains_top - 4'd1;
                if (grains_top == 4'd1) begin
                  st   <= EMPTY;
                  done <= 1'b1;
                end
              end else begin
                grain_sec <= grain_sec + 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end else if (st == HOLD) begin
            // Prescaler keeps its value so the interrupted second resumes.
            if (!pause) begin
              st <= RUN;
            end
          end else begin
`ifdef HOURGLASS_AUTOFLIP_EN
            prescaler <= prescaler + 1'b1;
`else
            prescaler <= '0;
`endif
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hourglass_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hourglass_ctrl
// Description : Directed self-checking bench for hourglass_ctrl with
//               CLK_HZ=10, C=4, N=2, START_DIR=0. Expected values are
//               hand-derived from the cycle timeline of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hourglass_ctrl;

  logic       clk;
  logic       rst;
  logic       flip;
  logic       pause;
  logic       step;
  logic       mirror;
  logic       dir;
  logic [3:0] grains_top;
  logic [6:0] sec_left;
  logic [1:0] state;
  logic       done;

  int checks = 0;
  int errors = 0;
  int step_cnt = 0;
  int mirror_cnt = 0;
  int snap_step;
  int snap_mirror;

  hourglass_ctrl #(
    .CLK_HZ   (10),
    .C        (4),
    .N        (2),
    .START_DIR(1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flip      (flip),
    .pause     (pause),
    .step      (step),
    .mirror    (mirror),
    .dir       (dir),
    .grains_top(grains_top),
    .sec_left  (sec_left),
    .state     (state),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (step === 1'b1)   step_cnt++;
    if (mirror === 1'b1) mirror_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n active edges, then settle 1 time unit past the last edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset, then pulse flip so that edge E0 enters RUN.
  task automatic start_run();
    rst = 1'b1;
    cyc(1);
    rst  = 1'b0;
    flip = 1'b1;
    cyc(1);
    flip = 1'b0;
  endtask

  task automatic pulse_flip();
    flip = 1'b1;
    cyc(1);
    flip = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    flip  = 1'b0;
    pause = 1'b0;
    #2;
    // Reset state
    check("rst_state", state, 0);
    check("rst_grains", grains_top, 4);
    check("rst_sec", sec_left, 8);
    check("rst_dir", dir, 0);
    check("rst_pulses", {step, mirror, done}, 0);

    // ---- Start and first grain (now at E0) ----
    start_run();
    snap_mirror = mirror_cnt;
    check("t2_state", state, 1);
    cyc(9);                                   // E9
    check("t2_sec_e9", sec_left, 8);
    cyc(1);                                   // E10
    check("t2_sec_e10", sec_left, 7);
    cyc(9);                                   // E19
    check("t2_nostep_e19", step, 0);
    cyc(1);                                   // E20
    check("t2_step_e20", step, 1);
    check("t2_grains_e20", grains_top, 3);
    check("t2_sec_e20", sec_left, 6);
    cyc(1);                                   // E21
    check("t2_step_1cyc", step, 0);
    check("t2_no_mirror", mirror_cnt - snap_mirror, 0);

    // ---- Drain to empty ----
    cyc(58);                                  // E79
    check("t3_sec_e79", sec_left, 1);
    check("t3_done_e79", done, 0);
    cyc(1);                                   // E80
    check("t3_grains", grains_top, 0);
    check("t3_sec", sec_left, 0);
    check("t3_done", done, 1);
    check("t3_state", state, 3);
    cyc(1);
    check("t3_done_1cyc", done, 0);
`ifndef HOURGLASS_AUTOFLIP_EN
    snap_step = step_cnt;
    cyc(50);
    check("t3_no_step", step_cnt - snap_step, 0);
    check("t3_still_empty", state, 3);
    // Flip out of EMPTY: full bulb drains in the other direction.
    pulse_flip();
    check("t3_flip_state", state, 1);
    check("t3_flip_dir", dir, 1);
    check("t3_flip_mirror", mirror, 1);
    check("t3_flip_grains", grains_top, 4);
    check("t3_flip_sec", sec_left, 8);
`endif

    // ---- Flip at grains_top=3, grain_sec=1 ----
    start_run();                              // E0
    cyc(32);                                  // E32
    check("t4_pre_grains", grains_top, 3);
    check("t4_pre_sec", sec_left, 5);
    pulse_flip();                             // E33
    check("t4_dir", dir, 1);
    check("t4_mirror", mirror, 1);
    check("t4_grains", grains_top, 1);
    check("t4_sec", sec_left, 2);
    check("t4_state", state, 1);
    cyc(1);                                   // E34
    check("t4_mirror_1cyc", mirror, 0);
    cyc(18);                                  // E52
    check("t4_nostep_e52", step, 0);
    check("t4_sec_e52", sec_left, 1);
    cyc(1);                                   // E53
    check("t4_step", step, 1);
    check("t4_empty", state, 3);
    check("t4_done", done, 1);

    // ---- Async reset mid-RUN while mirror is high ----
    start_run();
    cyc(32);
    pulse_flip();                             // mirror=1, dir=1 now
    rst = 1'b1;
    #1;
    check("r_state", state, 0);
    check("r_grains", grains_top, 4);
    check("r_sec", sec_left, 8);
    check("r_dir", dir, 0);
    check("r_pulses", {step, mirror, done}, 0);
    cyc(1);

    // ---- Pause mid-second ----
    start_run();                              // E0
    cyc(5);                                   // E5, prescaler=5
    pause = 1'b1;
    cyc(1);                                   // E6
    check("t5_hold", state, 2);
    cyc(14);                                  // E20
    check("t5_hold_state", state, 2);
    check("t5_hold_sec", sec_left, 8);
    pause = 1'b0;
    cyc(1);                                   // E21
    check("t5_resume", state, 1);
    cyc(4);                                   // E25
    check("t5_sec_e25", sec_left, 8);
    cyc(1);                                   // E26
    check("t5_sec_e26", sec_left, 7);

    // ---- Pause in IDLE is ignored; flip with pause enters HOLD ----
    rst = 1'b1;
    cyc(1);
    rst   = 1'b0;
    pause = 1'b1;
    cyc(3);
    check("idle_pause", state, 0);
    pulse_flip();
    check("idle_flip_hold", state, 2);
    check("idle_flip_nomirror", mirror, 0);
    check("idle_flip_dir", dir, 0);
    pause = 1'b0;
    cyc(1);

    // ---- Flip coincident with tick ----
    start_run();                              // E0
    cyc(29);                                  // E29, prescaler=9, grains=3
    snap_step = step_cnt;
    pulse_flip();                             // E30
    check("t6_mirror", mirror, 1);
    check("t6_step", step, 0);
    check("t6_done", done, 0);
    check("t6_grains", grains_top, 1);
    check("t6_sec", sec_left, 2);
    check("t6_state", state, 1);
    cyc(1);
    check("t6_no_step", step_cnt - snap_step, 0);
    cyc(19);                                  // E50
    check("t6_empty", state, 3);
    check("t6_done_drain", done, 1);
`ifdef HOURGLASS_AUTOFLIP_EN
    cyc(9);                                   // E59
    check("af_wait", state, 3);
    cyc(1);                                   // E60
    check("af_mirror", mirror, 1);
    check("af_dir", dir, 0);
    check("af_grains", grains_top, 4);
    check("af_state", state, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
